// File: rtl/kbd_mem_arbiter.sv
// Shares the CPU data-memory port with a keyboard writer that drains a scancode FIFO into a memory ring.
// Define KBD_DROP_CNT_EN to build the saturating dropped-code counter behind drop_count.
module kbd_mem_arbiter #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] RING_BASE  = 32'h2000,
  parameter int          RING_WORDS = 16,
  parameter int          STARVE_MAX = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          kbd_valid,
  input  logic [7:0]                    kbd_code,
  output logic                          kbd_ready,
  input  logic                          cpu_req,
  input  logic                          cpu_we,
  input  logic [31:0]                   cpu_addr,
  input  logic [31:0]                   cpu_wdata,
  output logic [31:0]                   cpu_rdata,
  output logic                          cpu_stall,
  output logic [31:0]                   mem_addr,
  output logic                          mem_we,
  output logic [31:0]                   mem_wdata,
  input  logic [31:0]                   mem_rdata,
  output logic [$clog2(RING_WORDS)-1:0] kbd_head,
  output logic [15:0]                   drop_count
);

  localparam int HW = $clog2(RING_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic {GNT_CPU, GNT_KBD} state_t;

  state_t        state_q, state_d;
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [7:0]    fifo_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [HW-1:0] head_q, head_d;
  logic [SW-1:0] starve_q, starve_d;

  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          kbd_write;
  logic          cpu_owner;
  logic [31:0]   ring_addr;

  // Ownership of the current cycle; everything is held quiet while reset is low.
  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == FULL_CNT);
    kbd_ready  = !fifo_full || !reset;
    push       = reset && kbd_valid && !fifo_full;
    kbd_write  = 1'b0;
    cpu_owner  = 1'b0;
    cpu_stall  = 1'b0;
    if (reset) begin
      if (state_q == GNT_KBD) begin
        kbd_write = !fifo_empty;
        cpu_stall = cpu_req;
      end else if (cpu_req) begin
        cpu_owner = 1'b1;
      end else begin
        kbd_write = !fifo_empty;
      end
    end
  end

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (push) begin
      fifo_d[wr_ptr_q] = kbd_code;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    if (kbd_write) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      head_d   = head_q + HW'(1);
    end
    case ({push, kbd_write})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Starve counter only grows while the CPU holds the port over a waiting code.
  always_comb begin
    starve_d = '0;
    state_d  = GNT_CPU;
    case (state_q)
      GNT_CPU: begin
        if (cpu_owner && !fifo_empty) begin
          starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + SW'(1);
          if (starve_d == STARVE_LIM) begin
            state_d = GNT_KBD;
          end
        end
      end
      GNT_KBD: begin
        starve_d = '0;
        state_d  = GNT_CPU;
      end
      default: begin
        starve_d = '0;
        state_d  = GNT_CPU;
      end
    endcase
  end

  always_comb begin
    ring_addr = RING_BASE + 32'({head_q, 2'b00});
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_we    = 1'b0;
    if (kbd_write) begin
      mem_addr  = ring_addr;
      mem_wdata = {24'h000000, fifo_q[rd_ptr_q]};
      mem_we    = 1'b1;
    end else if (cpu_owner) begin
      mem_we = cpu_we;
    end
  end

  assign cpu_rdata = mem_rdata;
  assign kbd_head  = head_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= GNT_CPU;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      starve_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      starve_q <= starve_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= fifo_d[i];
      end
    end
  end

`ifdef KBD_DROP_CNT_EN
  logic [15:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (kbd_valid && !kbd_ready && drop_q != 16'hFFFF) begin
      drop_d = drop_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign drop_count = drop_q;
`else
  assign drop_count = 16'h0000;
`endif

endmodule

// File: tb/tb_kbd_mem_arbiter.sv
// Self-checking bench for kbd_mem_arbiter: directed scenarios followed by random traffic,
// all compared cycle by cycle against a queue-based behavioural model.
module tb_kbd_mem_arbiter;

   localparam int          FIFO_DEPTH = 4;
   localparam logic [31:0] RING_BASE  = 32'h2000;
   localparam int          RING_WORDS = 16;
   localparam int          STARVE_MAX = 4;
`ifdef KBD_DROP_CNT_EN
   localparam bit DROP_EN = 1'b1;
`else
   localparam bit DROP_EN = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic        kbd_valid;
   logic [7:0]  kbd_code;
   logic        kbd_ready;
   logic        cpu_req;
   logic        cpu_we;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_stall;
   logic [31:0] mem_addr;
   logic        mem_we;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic [3:0]  kbd_head;
   logic [15:0] drop_count;

   int passCount;
   int failCount;
   int totalCount;

   // Behavioural model: pending codes, ring index, run of CPU cycles over waiting codes.
   logic [7:0] m_q[$];
   int         m_head;
   int         m_starve;
   bit         m_force;
   int         m_drops;

   kbd_mem_arbiter #(
      .FIFO_DEPTH(FIFO_DEPTH),
      .RING_BASE (RING_BASE),
      .RING_WORDS(RING_WORDS),
      .STARVE_MAX(STARVE_MAX)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .kbd_valid (kbd_valid),
      .kbd_code  (kbd_code),
      .kbd_ready (kbd_ready),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_stall (cpu_stall),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .kbd_head  (kbd_head),
      .drop_count(drop_count)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One comparison: counts it and reports any difference.
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      totalCount++;
      assert (obs === exp) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drives one cycle of inputs just after a falling edge.
   task automatic applyStimulus(input logic rst, input logic creq, input logic cwe,
                                input logic [31:0] caddr, input logic [31:0] cwdata,
                                input logic kv, input logic [7:0] kc);
      @(negedge clk);
      reset     = rst;
      cpu_req   = creq;
      cpu_we    = cwe;
      cpu_addr  = caddr;
      cpu_wdata = cwdata;
      kbd_valid = kv;
      kbd_code  = kc;
      mem_rdata = $urandom;
   endtask

   // Compares this cycle's outputs with the model, then advances the model past the next edge.
   task automatic checkOutput();
      bit          kw;
      bit          served;
      int          pend;
      logic        expReady;
      logic        expStall;
      logic        expWe;
      logic [31:0] expAddr;
      logic [31:0] expWdata;
      #1;
      pend     = m_q.size();
      kw       = 1'b0;
      served   = 1'b0;
      expStall = 1'b0;
      expReady = !reset ? 1'b1 : (pend < FIFO_DEPTH);
      if (reset) begin
         if (m_force) begin
            kw       = (pend > 0);
            expStall = cpu_req;
         end else if (cpu_req) begin
            served = 1'b1;
         end else begin
            kw = (pend > 0);
         end
      end
      expWe    = kw ? 1'b1 : (served ? cpu_we : 1'b0);
      expAddr  = kw ? RING_BASE + 32'(m_head * 4) : cpu_addr;
      expWdata = kw ? {24'h000000, m_q[0]} : cpu_wdata;
      check("kbd_ready", 32'(kbd_ready), 32'(expReady));
      check("cpu_stall", 32'(cpu_stall), 32'(expStall));
      check("mem_we", 32'(mem_we), 32'(expWe));
      check("mem_addr", mem_addr, expAddr);
      if (expWe) check("mem_wdata", mem_wdata, expWdata);
      check("kbd_head", 32'(kbd_head), 32'(m_head));
      check("drop_count", 32'(drop_count), DROP_EN ? 32'(m_drops) : 32'h0);
      check("cpu_rdata", cpu_rdata, mem_rdata);
      if (!reset) begin
         m_q.delete();
         m_head   = 0;
         m_starve = 0;
         m_force  = 1'b0;
         m_drops  = 0;
      end else begin
         if (kw) begin
            void'(m_q.pop_front());
            m_head = (m_head + 1) % RING_WORDS;
         end
         if (kbd_valid && pend < FIFO_DEPTH) m_q.push_back(kbd_code);
         else if (kbd_valid && m_drops < 65535) m_drops++;
         if (served && pend > 0) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : m_starve;
         else m_starve = 0;
         m_force = served && (pend > 0) && (m_starve == STARVE_MAX);
      end
   endtask

   // Directed scenarios first, then randomized traffic with occasional resets.
   initial begin
      passCount  = 0;
      failCount  = 0;
      totalCount = 0;
      m_head     = 0;
      m_starve   = 0;
      m_force    = 1'b0;
      m_drops    = 0;
      reset      = 1'b0;
      cpu_req    = 1'b0;
      cpu_we     = 1'b0;
      cpu_addr   = 32'h0;
      cpu_wdata  = 32'h0;
      kbd_valid  = 1'b0;
      kbd_code   = 8'h00;
      mem_rdata  = 32'h0;

      $display("[TB] reset state");
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 8'h00);
         checkOutput();
      end
      check("rst_head", 32'(kbd_head), 32'h0);
      check("rst_ready", 32'(kbd_ready), 32'h1);

      $display("[TB] idle steal of one code");
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 1'b1, 8'h29);
      checkOutput();
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 8'h00);
      checkOutput();
      check("steal_addr", mem_addr, 32'h2000);
      check("steal_we", 32'(mem_we), 32'h1);
      check("steal_wdata", mem_wdata, 32'h29);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 8'h00);
      checkOutput();
      check("steal_head", 32'(kbd_head), 32'h1);

      $display("[TB] forced keyboard slot under continuous CPU traffic");
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 8'h00);
      checkOutput();
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h400, 32'hA5A5_0000, 1'b1, 8'h1D);
      checkOutput();
      for (int k = 1; k <= 6; k++) begin
         applyStimulus(1'b1, 1'b1, k[0], 32'h400 + 32'(k * 4), 32'hA5A5_0000 + 32'(k), 1'b0, 8'h00);
         checkOutput();
         if (k == 4) check("starve_still_cpu", 32'(cpu_stall), 32'h0);
         if (k == 5) begin
            check("forced_stall", 32'(cpu_stall), 32'h1);
            check("forced_addr", mem_addr, 32'h2000);
            check("forced_wdata", mem_wdata, 32'h1D);
         end
         if (k == 6) check("forced_release", 32'(cpu_stall), 32'h0);
      end

      $display("[TB] ring wrap after 17 codes");
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 8'h00);
      checkOutput();
      for (int i = 0; i < 17; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 8'(i + 1));
         checkOutput();
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 8'h00);
      checkOutput();
      check("wrap_addr", mem_addr, 32'h2000);
      check("wrap_wdata", mem_wdata, 32'h11);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 8'h00);
      checkOutput();
      check("wrap_head", 32'(kbd_head), 32'h1);

      $display("[TB] FIFO overflow under CPU pressure");
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 8'h00);
      checkOutput();
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 32'h800, 32'h0, 1'b1, 8'(8'h40 + i));
         checkOutput();
         if (i == 4) check("full_ready", 32'(kbd_ready), 32'h0);
      end
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h800, 32'h0, 1'b0, 8'h00);
      checkOutput();
      check("drop_total", 32'(drop_count), DROP_EN ? 32'h2 : 32'h0);

      $display("[TB] reset with codes queued");
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 8'h00);
      checkOutput();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 32'h900, 32'h0, 1'b1, 8'(8'h70 + i));
         checkOutput();
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h900, 32'h0, 1'b0, 8'h00);
      checkOutput();
      check("rst_mid_we", 32'(mem_we), 32'h0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 32'h900, 32'h0, 1'b0, 8'h00);
         checkOutput();
         check("post_rst_we", 32'(mem_we), 32'h0);
         check("post_rst_head", 32'(kbd_head), 32'h0);
      end

      $display("[TB] random traffic");
      for (int i = 0; i < 600; i++) begin
         applyStimulus($urandom_range(0, 99) != 0,
                       $urandom_range(0, 99) < 70,
                       1'($urandom),
                       $urandom,
                       $urandom,
                       $urandom_range(0, 99) < 45,
                       8'($urandom));
         checkOutput();
      end

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule
